sprite_renderer: RTL



---
 rtl/sprite_pkg.sv | 19 +
 rtl/sprite_hit_calc.sv | 55 +++++
 rtl/sprite_renderer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and constants for the sprite renderer slice.
// Optional feature macro used by this slice: SPRITE_MIRROR_EN (horizontal flip).
package sprite_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef enum logic {
      POS_IDLE    = 1'b0,
      POS_PENDING = 1'b1
   } pos_state_t;

   // Pixel-in to sprite-out latency; downstream sync/blank delay lines use the same value.
   localparam int SPR_LAT = 3;

endpackage

// File: rtl/sprite_hit_calc.sv
// sprite_hit_calc: combinational bounds test and sprite ROM address for pipeline stage S0.
// The mirror input is tied low by the top unless SPRITE_MIRROR_EN is defined.
module sprite_hit_calc #(
   parameter int SPR_W    = 32,
   parameter int SPR_H    = 32,
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480
) (
   input  logic [9:0]                             h_pos,
   input  logic [9:0]                             v_pos,
   input  logic [9:0]                             spr_x,
   input  logic [9:0]                             spr_y,
   input  logic                                   spr_en,
   input  logic                                   mirror,
   output logic                                   hit,
   output logic [$clog2(SPR_W)+$clog2(SPR_H)-1:0] addr
);

   localparam int CW = $clog2(SPR_W);
   localparam int RW = $clog2(SPR_H);

   logic [10:0]   h_ext;
   logic [10:0]   v_ext;
   logic [10:0]   x_ext;
   logic [10:0]   y_ext;
   logic [10:0]   x_end;
   logic [10:0]   y_end;
   logic          in_x;
   logic          in_y;
   logic          visible;
   logic [CW-1:0] col;
   logic [RW-1:0] row;

   // Bounds are compared in 11 bits so a sprite near the right/bottom edge never wraps to column/line 0;
   // only the low index bits of the offsets are needed because the sprite size is a power of two.
   always_comb begin
      h_ext   = {1'b0, h_pos};
      v_ext   = {1'b0, v_pos};
      x_ext   = {1'b0, spr_x};
      y_ext   = {1'b0, spr_y};
      x_end   = x_ext + 11'(SPR_W);
      y_end   = y_ext + 11'(SPR_H);
      in_x    = (h_ext >= x_ext) && (h_ext < x_end);
      in_y    = (v_ext >= y_ext) && (v_ext < y_end);
      visible = (h_ext < 11'(H_ACTIVE)) && (v_ext < 11'(V_ACTIVE));
      hit     = spr_en && in_x && in_y && visible;
      col     = h_pos[CW-1:0] - spr_x[CW-1:0];
      if (mirror) begin
         col = CW'(SPR_W - 1) - col;
      end
      row     = v_pos[RW-1:0] - spr_y[RW-1:0];
      addr    = {row, col};
   end

endmodule

// File: rtl/sprite_renderer.sv
// sprite_renderer: 3-cycle pixel-rate sprite stage feeding the background/sprite merge.
// Position updates arrive on a valid/ready handshake and are committed only at the frame boundary.
// Optional feature: define SPRITE_MIRROR_EN to add the mirror_x input (horizontal flip).
module sprite_renderer
   import sprite_pkg::*;
#(
   parameter int          SPR_W     = 32,
   parameter int          SPR_H     = 32,
   parameter int          H_ACTIVE  = 640,
   parameter int          V_ACTIVE  = 480,
   parameter logic [23:0] KEY_COLOR = 24'hFF00FF,
   parameter int          INIT_X    = 0,
   parameter int          INIT_Y    = 0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [9:0]                     h_pos,
   input  logic [9:0]                     v_pos,
   input  logic                           spr_en,
   input  logic [9:0]                     pos_x,
   input  logic [9:0]                     pos_y,
   input  logic                           pos_valid,
`ifdef SPRITE_MIRROR_EN
   input  logic                           mirror_x,
`endif
   output logic                           pos_ready,
   output logic [$clog2(SPR_W*SPR_H)-1:0] rom_addr,
   input  logic [23:0]                    rom_data,
   output logic                           sprite_valid,
   output logic [7:0]                     sprite_R,
   output logic [7:0]                     sprite_G,
   output logic [7:0]                     sprite_B,
   output logic                           commit_pulse
);

   localparam int AW = $clog2(SPR_W*SPR_H);

   pos_state_t    state_q;
   pos_state_t    state_d;
   logic          accept;
   logic          frame_boundary;
   logic [9:0]    pend_x_q;
   logic [9:0]    pend_y_q;
   logic [9:0]    cur_x_q;
   logic [9:0]    cur_y_q;
   logic          cur_mirror;
   logic          hit;
   logic [AW-1:0] hit_addr;
   logic          hit_d1_q;
   logic          hit_d2_q;
   logic          opaque;
   rgb_t          sprite_rgb_q;

   assign frame_boundary = (h_pos == 10'd0) && (v_pos == 10'(V_ACTIVE));
   assign opaque         = hit_d2_q && (rom_data != KEY_COLOR);

   // Position handshake state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= POS_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Accept one request while idle, then hold it until the next frame boundary (never the accept cycle itself).
   always_comb begin
      state_d      = state_q;
      pos_ready    = 1'b0;
      accept       = 1'b0;
      commit_pulse = 1'b0;
      case (state_q)
         POS_IDLE: begin
            pos_ready = 1'b1;
            if (pos_valid) begin
               accept  = 1'b1;
               state_d = POS_PENDING;
            end
         end
         POS_PENDING: begin
            if (frame_boundary) begin
               commit_pulse = 1'b1;
               state_d      = POS_IDLE;
            end
         end
      endcase
   end

   // Pending and committed sprite position; reset discards any pending request.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_x_q <= 10'd0;
         pend_y_q <= 10'd0;
         cur_x_q  <= 10'(INIT_X);
         cur_y_q  <= 10'(INIT_Y);
      end else begin
         if (accept) begin
            pend_x_q <= pos_x;
            pend_y_q <= pos_y;
         end
         if (commit_pulse) begin
            cur_x_q <= pend_x_q;
            cur_y_q <= pend_y_q;
         end
      end
   end

`ifdef SPRITE_MIRROR_EN
   logic pend_mirror_q;
   logic cur_mirror_q;

   // The mirror flag travels with the position through pending and commit.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_mirror_q <= 1'b0;
         cur_mirror_q  <= 1'b0;
      end else begin
         if (accept) begin
            pend_mirror_q <= mirror_x;
         end
         if (commit_pulse) begin
            cur_mirror_q <= pend_mirror_q;
         end
      end
   end

   assign cur_mirror = cur_mirror_q;
`else
   assign cur_mirror = 1'b0;
`endif

   sprite_hit_calc #(
      .SPR_W    (SPR_W),
      .SPR_H    (SPR_H),
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE)
   ) u_hit_calc (
      .h_pos  (h_pos),
      .v_pos  (v_pos),
      .spr_x  (cur_x_q),
      .spr_y  (cur_y_q),
      .spr_en (spr_en),
      .mirror (cur_mirror),
      .hit    (hit),
      .addr   (hit_addr)
   );

   // S0..S2: register the address on a hit, track the hit alongside the ROM read, then key out transparent pixels.
   always_ff @(posedge clk) begin
      if (rst) begin
         rom_addr     <= '0;
         hit_d1_q     <= 1'b0;
         hit_d2_q     <= 1'b0;
         sprite_valid <= 1'b0;
         sprite_rgb_q <= '0;
      end else begin
         if (hit) begin
            rom_addr <= hit_addr;
         end
         hit_d1_q     <= hit;
         hit_d2_q     <= hit_d1_q;
         sprite_valid <= opaque;
         sprite_rgb_q <= opaque ? rgb_t'(rom_data) : '0;
      end
   end

   assign sprite_R = sprite_rgb_q.r;
   assign sprite_G = sprite_rgb_q.g;
   assign sprite_B = sprite_rgb_q.b;

endmodule
